// File: rtl/demux_1to3.sv
// Registered 1-to-3 demultiplexer with per-channel one-entry holding registers.
// Invalid select codes are consumed, flagged (sticky) and counted (saturating).
module demux_1to3 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic [WIDTH-1:0] c_data,
    output logic             sel_err,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_state   [3];
    ch_state_t        w_state_nx[3];
    logic [WIDTH-1:0] r_data    [3];
    logic             r_sel_err;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [2:0] w_tgt;
    logic       w_bad;
    logic [2:0] w_x_ready;
    logic [2:0] w_room;
    logic [2:0] w_load;
    logic       w_acc;
    logic       w_drop;

    always_comb begin
        w_tgt = 3'b000;
        w_bad = 1'b0;
        case (in_sel)
            3'b000:  w_tgt = 3'b001;
            3'b010:  w_tgt = 3'b010;
            3'b100:  w_tgt = 3'b100;
            default: w_bad = 1'b1;
        endcase
    end

    assign w_x_ready = {c_ready, b_ready, a_ready};

    // A full channel can still take a beat when its consumer drains it this cycle.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_room[i] = (r_state[i] == ST_EMPTY) || w_x_ready[i];
        end
    end

    assign in_ready = w_bad | (|(w_tgt & w_room));
    assign w_acc    = in_valid & in_ready & ~reset;
    assign w_load   = w_acc ? w_tgt : 3'b000;
    assign w_drop   = w_acc & w_bad;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_state_nx[i] = r_state[i];
            if (w_load[i]) begin
                w_state_nx[i] = ST_FULL;
            end else if (r_state[i] == ST_FULL && w_x_ready[i]) begin
                w_state_nx[i] = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                r_state[i] <= ST_EMPTY;
                r_data[i]  <= '0;
            end else begin
                r_state[i] <= w_state_nx[i];
                if (w_load[i]) begin
                    r_data[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err  <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_sel_err <= 1'b1;
            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign a_valid  = (r_state[0] == ST_FULL);
    assign b_valid  = (r_state[1] == ST_FULL);
    assign c_valid  = (r_state[2] == ST_FULL);
    assign a_data   = r_data[0];
    assign b_data   = r_data[1];
    assign c_data   = r_data[2];
    assign sel_err  = r_sel_err;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_1to3.sv
// Directed vector bench for demux_1to3: routing, backpressure refill,
// invalid-code dropping with saturation, and mid-operation reset.
module tb_demux_1to3;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic       a_valid, a_ready;
    logic [7:0] a_data;
    logic       b_valid, b_ready;
    logic [7:0] b_data;
    logic       c_valid, c_ready;
    logic [7:0] c_data;
    logic       sel_err;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    demux_1to3 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
        .sel_err(sel_err), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v;
        logic [2:0] sel;
        logic [7:0] d;
        logic [2:0] rdy;     // {c,b,a}
        logic       e_rdy;   // checked only when v = 1
        logic [2:0] e_val;   // {c,b,a} after the edge
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic [7:0] e_c;
        logic       e_err;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [2:0] sel,
                       input logic [7:0] d, input logic [2:0] rdy,
                       input logic e_rdy, input logic [2:0] e_val,
                       input logic [7:0] e_a, input logic [7:0] e_b,
                       input logic [7:0] e_c, input logic e_err,
                       input logic [7:0] e_cnt);
        vec_t t;
        t.rst = rst; t.v = v; t.sel = sel; t.d = d; t.rdy = rdy;
        t.e_rdy = e_rdy; t.e_val = e_val;
        t.e_a = e_a; t.e_b = e_b; t.e_c = e_c;
        t.e_err = e_err; t.e_cnt = e_cnt;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [2:0] sel,
                         input logic [7:0] d, input logic [2:0] rdy);
        reset = rst; in_valid = v; in_sel = sel; in_data = d;
        {c_ready, b_ready, a_ready} = rdy;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] e_val,
                              input logic [7:0] e_a, input logic [7:0] e_b,
                              input logic [7:0] e_c, input logic e_err,
                              input logic [7:0] e_cnt);
        check({tag, " valid"}, {29'd0, c_valid, b_valid, a_valid}, {29'd0, e_val});
        if (e_val[0]) check({tag, " a_data"}, {24'd0, a_data}, {24'd0, e_a});
        if (e_val[1]) check({tag, " b_data"}, {24'd0, b_data}, {24'd0, e_b});
        if (e_val[2]) check({tag, " c_data"}, {24'd0, c_data}, {24'd0, e_c});
        check({tag, " sel_err"}, {31'd0, sel_err}, {31'd0, e_err});
        check({tag, " drop_cnt"}, {24'd0, drop_cnt}, {24'd0, e_cnt});
    endtask

    initial begin
        //  rst v  sel     d      rdy     erdy eval    a      b      c      err  cnt
        add(1, 0, 3'b000, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
        // single beat to b
        add(0, 1, 3'b010, 8'h5A, 3'b111, 1, 3'b010, 8'h00, 8'h5A, 8'h00, 0, 8'd0);
        add(0, 0, 3'b010, 8'h5A, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
        // backpressure on c, then pass-through refill
        add(0, 1, 3'b100, 8'h11, 3'b011, 1, 3'b100, 8'h00, 8'h00, 8'h11, 0, 8'd0);
        add(0, 1, 3'b100, 8'h22, 3'b011, 0, 3'b100, 8'h00, 8'h00, 8'h11, 0, 8'd0);
        add(0, 1, 3'b100, 8'h22, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h22, 0, 8'd0);
        add(0, 0, 3'b000, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
        // back-to-back a, b, c, a
        add(0, 1, 3'b000, 8'h01, 3'b111, 1, 3'b001, 8'h01, 8'h00, 8'h00, 0, 8'd0);
        add(0, 1, 3'b010, 8'h02, 3'b111, 1, 3'b010, 8'h00, 8'h02, 8'h00, 0, 8'd0);
        add(0, 1, 3'b100, 8'h03, 3'b111, 1, 3'b100, 8'h00, 8'h00, 8'h03, 0, 8'd0);
        add(0, 1, 3'b000, 8'h04, 3'b111, 1, 3'b001, 8'h04, 8'h00, 8'h00, 0, 8'd0);
        add(0, 0, 3'b000, 8'h00, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
        // invalid codes, last one with all consumers stalled
        add(0, 1, 3'b001, 8'hAA, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd1);
        add(0, 1, 3'b111, 8'hBB, 3'b111, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd2);
        add(0, 1, 3'b011, 8'hCC, 3'b000, 1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'd3);

        drive(1, 0, 3'b000, 8'h00, 3'b111);
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vecs[i].rst, vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
            #1;
            if (vecs[i].v)
                check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            @(posedge clk);
            #1;
            check_outs(tag, vecs[i].e_val, vecs[i].e_a, vecs[i].e_b,
                       vecs[i].e_c, vecs[i].e_err, vecs[i].e_cnt);
        end

        // 300 more invalid beats: count saturates at FF without wrapping
        for (int n = 0; n < 300; n++) begin
            drive(0, 1, 3'b101, n[7:0], 3'b111);
            #1;
            if (n == 0 || n == 299)
                check($sformatf("sat%0d in_ready", n), {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (n == 99)
                check("sat mid drop_cnt", {24'd0, drop_cnt}, 32'h67);
            if (n == 251)
                check("sat reach drop_cnt", {24'd0, drop_cnt}, 32'hFF);
        end
        check_outs("sat end", 3'b000, 8'h00, 8'h00, 8'h00, 1, 8'hFF);

        // fill a and b with stalled consumers, then reset mid-operation
        drive(0, 1, 3'b000, 8'h77, 3'b000);
        @(posedge clk);
        #1;
        drive(0, 1, 3'b010, 8'h88, 3'b000);
        @(posedge clk);
        #1;
        check_outs("fill", 3'b011, 8'h77, 8'h88, 8'h00, 1, 8'hFF);
        drive(1, 1, 3'b100, 8'h99, 3'b000);
        @(posedge clk);
        #1;
        check_outs("rst", 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);
        check("rst a_data", {24'd0, a_data}, 32'd0);
        check("rst b_data", {24'd0, b_data}, 32'd0);
        drive(0, 0, 3'b000, 8'h00, 3'b111);
        @(posedge clk);
        #1;
        check_outs("post rst", 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
